// File: rtl/sau_issue_sched.sv
// -----------------------------------------------------------------------------
// sau_issue_sched
//
// Shares one fixed-latency SAU (systolic array unit) datapath between
// NUM_REQS dispatch-side requesters. One request is granted at a time using
// round-robin arbitration. Each operation then passes through these states:
//   IDLE -> ISSUE (one-cycle sau_start) -> COMPUTE (lat cycles) -> RESP
// The result is returned tagged with the index of the requester that issued it.
//
// Ports
//   clk          clock
//   reset_n      asynchronous active-low reset
//   req_valid    per-requester request valid                  [NUM_REQS]
//   req_data     per-requester payload, slice i = [i*DATAW +: DATAW]
//   req_ready    per-requester accept, one-hot or zero        [NUM_REQS]
//   cfg_latency  SAU compute latency, sampled on accept; 0 acts as 1
//   sau_start    one-cycle start pulse to the SAU
//   sau_data     registered payload of the granted request    [DATAW]
//   sau_result   SAU result, valid in the last compute cycle  [RESW]
//   rsp_valid    response valid
//   rsp_ready    response accept
//   rsp_idx      requester index of the response
//   rsp_data     registered SAU result                        [RESW]
//   busy         high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module sau_issue_sched #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64,
    parameter int RESW     = 32,
    parameter int LATW     = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*DATAW-1:0]     req_data,
    output logic [NUM_REQS-1:0]           req_ready,
    input  logic [LATW-1:0]               cfg_latency,
    output logic                          sau_start,
    output logic [DATAW-1:0]              sau_data,
    input  logic [RESW-1:0]               sau_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQS)-1:0]   rsp_idx,
    output logic [RESW-1:0]               rsp_data,
    output logic                          busy
);

    localparam int IDXW = $clog2(NUM_REQS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COMPUTE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [IDXW-1:0]   rr_ptr_reg;
    logic [LATW-1:0]   lat_reg;
    logic [LATW-1:0]   counter_reg;
    logic [DATAW-1:0]  sau_data_reg;
    logic [RESW-1:0]   rsp_data_reg;
    logic [IDXW-1:0]   rsp_idx_reg;

    logic [IDXW-1:0]   grant_idx;
    logic [IDXW-1:0]   cand_idx;
    logic              grant_found;
    logic              accept;
    logic [IDXW-1:0]   rr_ptr_next;
    logic [LATW-1:0]   lat_sel;
    logic [DATAW-1:0]  req_slice [NUM_REQS];

    // ------------------------------------------------------------------
    // Round-robin grant: first valid requester at or after rr_ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand_idx = IDXW'((int'(rr_ptr_reg) + k) % NUM_REQS);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // A grant only exists while idle, so req_ready is also the accept strobe.
    assign accept = (state_reg == IDLE) && grant_found;

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
            assign req_slice[gi] = req_data[gi*DATAW +: DATAW];
            assign req_ready[gi] = accept && (grant_idx == IDXW'(gi));
        end
    endgenerate

    // The pointer moves past the winner; it is non-power-of-two safe.
    assign rr_ptr_next = (grant_idx == IDXW'(NUM_REQS - 1)) ? '0 : grant_idx + IDXW'(1);

    // A zero latency would make the countdown wrap, so it is clamped to 1.
    assign lat_sel = (cfg_latency == '0) ? LATW'(1) : cfg_latency;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        sau_start  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                sau_start  = 1'b1;
                state_next = COMPUTE;
            end
            COMPUTE: begin
                if (counter_reg == LATW'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg   <= '0;
            lat_reg      <= '0;
            counter_reg  <= '0;
            sau_data_reg <= '0;
            rsp_data_reg <= '0;
            rsp_idx_reg  <= '0;
        end else begin
            if (accept) begin
                sau_data_reg <= req_slice[grant_idx];
                rsp_idx_reg  <= grant_idx;
                lat_reg      <= lat_sel;
                rr_ptr_reg   <= rr_ptr_next;
            end
            if (state_reg == ISSUE) begin
                counter_reg <= lat_reg;
            end
            if (state_reg == COMPUTE) begin
                counter_reg <= counter_reg - LATW'(1);
                // counter==1 marks the last compute cycle, when the SAU
                // drives its result.
                if (counter_reg == LATW'(1)) begin
                    rsp_data_reg <= sau_result;
                end
            end
        end
    end

    assign sau_data = sau_data_reg;
    assign rsp_data = rsp_data_reg;
    assign rsp_idx  = rsp_idx_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_sau_issue_sched.sv
// -----------------------------------------------------------------------------
// tb_sau_issue_sched
//
// Cycle-stepped bench for sau_issue_sched. A transaction-level model keeps the
// round-robin pointer and the expected timing of each operation:
//   accept A, start A+1, result sampled A+1+lat, response from A+2+lat.
// Inputs are driven 1 time unit after the rising edge and outputs are checked
// 2 units later.
// -----------------------------------------------------------------------------
module tb_sau_issue_sched;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int RW = 32;
    localparam int LW = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [LW-1:0]     cfg_latency;
    logic              sau_start;
    logic [DW-1:0]     sau_data;
    logic [RW-1:0]     sau_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_idx;
    logic [RW-1:0]     rsp_data;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_rr     = 0;

    always #5 clk = ~clk;

    sau_issue_sched #(
        .NUM_REQS (N),
        .DATAW    (DW),
        .RESW     (RW),
        .LATW     (LW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .cfg_latency (cfg_latency),
        .sau_start   (sau_start),
        .sau_data    (sau_data),
        .sau_result  (sau_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_idx     (rsp_idx),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    // First valid requester searching upward from the model pointer.
    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (model_rr + k) % N;
            if (v[c[IW-1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_payloads();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = {$urandom, $urandom};
        end
    endtask

    // One complete operation, starting in an idle cycle. v_acc is presented in
    // the accept cycle, v_busy while the block is busy. cfg_latency and the
    // payloads are scrambled after accept. bp = cycles of rsp_ready=0 in RESP.
    // gobs returns the requester index the DUT actually granted.
    task automatic do_op(input logic [N-1:0] v_acc, input logic [N-1:0] v_busy,
                         input logic [LW-1:0] cfg, input int bp,
                         input logic [RW-1:0] res_val, input string tag,
                         output int gobs);
        int            g;
        int            lat;
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_data;
        logic [IW-1:0] exp_idx;

        req_valid   = v_acc;
        cfg_latency = cfg;
        rsp_ready   = 1'b0;
        sau_result  = $urandom;
        randomize_payloads();
        #2;
        g         = model_grant(v_acc);
        lat       = (cfg == '0) ? 1 : int'(cfg);
        exp_ready = '0;
        exp_ready[g[IW-1:0]] = 1'b1;
        exp_idx   = g[IW-1:0];
        exp_data  = req_data[g*DW +: DW];
        gobs = -1;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i[IW-1:0]]) gobs = i;
        end
        tests_run++;
        if (req_ready !== exp_ready) begin
            tests_failed++;
            $display("FAIL %s accept req_ready got=%b exp=%b", tag, req_ready, exp_ready);
        end
        tests_run++;
        if (busy !== 1'b0 || sau_start !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s idle_outputs busy/start/rsp got=%b%b%b exp=000", tag, busy, sau_start, rsp_valid);
        end

        // ISSUE cycle (A+1)
        step();
        req_valid   = v_busy;
        cfg_latency = LW'($urandom);
        rsp_ready   = 1'($urandom);
        randomize_payloads();
        #2;
        tests_run++;
        if (sau_start !== 1'b1 || busy !== 1'b1 || req_ready !== '0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s issue start/busy/ready/rsp got=%b%b%b%b exp=1100000", tag, sau_start, busy, req_ready, rsp_valid);
        end
        tests_run++;
        if (sau_data !== exp_data) begin
            tests_failed++;
            $display("FAIL %s sau_data got=%h exp=%h", tag, sau_data, exp_data);
        end

        // COMPUTE cycles A+2 .. A+1+lat; only the last one carries the result.
        for (int c = 1; c <= lat; c++) begin
            step();
            sau_result  = (c == lat) ? res_val : $urandom;
            cfg_latency = LW'($urandom);
            rsp_ready   = 1'($urandom);
            #2;
            tests_run++;
            if (sau_start !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
                tests_failed++;
                $display("FAIL %s compute_c%0d start/rsp/busy/ready got=%b%b%b%b exp=0010000", tag, c, sau_start, rsp_valid, busy, req_ready);
            end
        end

        // RESP from A+2+lat, held for bp cycles of backpressure.
        for (int b = 0; b <= bp; b++) begin
            step();
            sau_result = $urandom;
            rsp_ready  = (b == bp);
            #2;
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_idx !== exp_idx || rsp_data !== res_val || req_ready !== '0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s resp_b%0d valid=%b idx=%0d data=%h ready=%b busy=%b exp valid=1 idx=%0d data=%h ready=0000 busy=1",
                         tag, b, rsp_valid, rsp_idx, rsp_data, req_ready, busy, exp_idx, res_val);
            end
        end

        // Handshake done: idle on the next cycle; requesters stand down.
        step();
        req_valid = '0;
        #2;
        tests_run++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s after_handshake rsp_valid/busy got=%b%b exp=00", tag, rsp_valid, busy);
        end
        model_rr = (g + 1) % N;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        cfg_latency = '0;
        sau_result  = '0;
        rsp_ready   = 1'b0;
        repeat (3) step();
        #2;
        tests_run++;
        if (busy !== 1'b0 || sau_start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0) begin
            tests_failed++;
            $display("FAIL reset ctrl busy/start/rsp/ready got=%b%b%b%b exp=0000000", busy, sau_start, rsp_valid, req_ready);
        end
        tests_run++;
        if (sau_data !== '0 || rsp_data !== '0 || rsp_idx !== '0) begin
            tests_failed++;
            $display("FAIL reset data sau_data=%h rsp_data=%h rsp_idx=%0d exp all 0", sau_data, rsp_data, rsp_idx);
        end
        reset_n  = 1'b1;
        model_rr = 0;
    endtask

    task automatic test_round_robin();
        int exp_a[5] = '{0, 1, 2, 3, 0};
        int exp_b[3] = '{1, 3, 1};
        int g;
        for (int i = 0; i < 5; i++) begin
            do_op(4'b1111, 4'b1111, 4'd3, 0, $urandom, "rr_all", g);
            tests_run++;
            if (g !== exp_a[i]) begin
                tests_failed++;
                $display("FAIL rr_all grant_%0d got=%0d exp=%0d", i, g, exp_a[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_op(4'b1010, 4'b1010, 4'd3, 0, $urandom, "rr_13", g);
            tests_run++;
            if (g !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL rr_13 grant_%0d got=%0d exp=%0d", i, g, exp_b[i]);
            end
        end
    endtask

    task automatic test_single();
        int g;
        do_op(4'b0001, 4'b0000, 4'd3, 0, 32'h0000_DEAD, "single", g);
        tests_run++;
        if (g !== 0) begin
            tests_failed++;
            $display("FAIL single grant got=%0d exp=0", g);
        end
    endtask

    task automatic test_backpressure();
        int g;
        do_op(4'b1111, 4'b1111, 4'd2, 10, $urandom, "backpressure", g);
    endtask

    task automatic test_latency_edges();
        int g;
        do_op(4'b0100, 4'b0000, 4'd0, 0, $urandom, "lat0", g);
        do_op(4'b1000, 4'b0011, 4'd15, 1, $urandom, "lat15", g);
        do_op(4'b0010, 4'b0000, 4'd1, 0, $urandom, "lat1", g);
    endtask

    task automatic test_reset_mid_op();
        int g;
        req_valid   = 4'b1111;
        cfg_latency = 4'd6;
        randomize_payloads();
        step();          // ISSUE
        step();          // COMPUTE
        step();          // COMPUTE
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || sau_start !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid ctrl busy/start/rsp got=%b%b%b exp=000", busy, sau_start, rsp_valid);
        end
        tests_run++;
        if (sau_data !== '0 || rsp_data !== '0 || rsp_idx !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid data sau_data=%h rsp_data=%h rsp_idx=%0d exp all 0", sau_data, rsp_data, rsp_idx);
        end
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_mid req_ready got=%b exp=0001", req_ready);
        end
        req_valid = '0;
        repeat (2) step();
        #2;
        reset_n  = 1'b1;
        model_rr = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            #2;
            tests_run++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid no_rsp_c%0d rsp_valid/busy got=%b%b exp=00", c, rsp_valid, busy);
            end
        end
        do_op(4'b1111, 4'b1111, 4'd2, 0, $urandom, "after_reset", g);
        tests_run++;
        if (g !== 0) begin
            tests_failed++;
            $display("FAIL after_reset grant got=%0d exp=0", g);
        end
    endtask

    task automatic test_withdrawn();
        int g;
        // Requester 2 asserts only while busy and is gone by the idle cycle.
        do_op(4'b0001, 4'b0100, 4'd3, 2, $urandom, "withdrawn", g);
        for (int c = 0; c < 3; c++) begin
            step();
            #2;
            tests_run++;
            if (req_ready !== '0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL withdrawn idle_c%0d req_ready/busy got=%b%b exp=00000", c, req_ready, busy);
            end
        end
        do_op(4'b1111, 4'b1111, 4'd2, 0, $urandom, "withdrawn_next", g);
        tests_run++;
        if (g !== 1) begin
            tests_failed++;
            $display("FAIL withdrawn_next grant got=%0d exp=1", g);
        end
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 20; i++) begin
            do_op(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                  LW'($urandom), $urandom_range(0, 3), $urandom, "random", g);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_latency_edges();
        test_reset_mid_op();
        test_withdrawn();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sau_issue_sched.md
Name: sau_issue_sched

Overview:
- Shares one fixed-latency SAU (systolic array unit) datapath between NUM_REQS dispatch-side requesters.
- Sits between the per-source SAU request buffers and the SAU execute unit.
- Grants one requester at a time using round-robin arbitration.
- Sequences each operation through the states issue, compute countdown and response handshake.
- Returns the result tagged with the index of the requester that issued it.

Parameters:
- NUM_REQS, 4, number of requesters (2..8).
- DATAW, 64, opaque request payload width forwarded to the SAU.
- RESW, 32, SAU result width.
- LATW, 4, width of the compute-latency configuration.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_data  in  NUM_REQS*DATAW  per-requester payload; requester i occupies slice [i*DATAW +: DATAW].
- req_ready  out  NUM_REQS  per-requester accept.
- cfg_latency  in  LATW  SAU compute latency in cycles; sampled on accept; 0 is treated as 1.
- sau_start  out  1  one-cycle start pulse to the SAU.
- sau_data  out  DATAW  registered payload of the granted request.
- sau_result  in  RESW  SAU result; valid in the last compute cycle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_idx  out  $clog2(NUM_REQS)  requester index of the response.
- rsp_data  out  RESW  registered result.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; rr_ptr=0; counter=0.
  - sau_start=0, rsp_valid=0, busy=0.
  - sau_data, rsp_data and rsp_idx reset to 0.
  - Reset asserted mid-operation aborts the operation with no response; the abandoned SAU result is ignored.
- States are IDLE, ISSUE, COMPUTE and RESP.
- IDLE:
  - The grant is combinational round-robin. It picks the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQS.
  - req_ready[i] = (state==IDLE) && grant[i]. This is one-hot or all zero, and is 0 in every other state.
  - On accept (req_valid[g] && req_ready[g]) the block:
    - latches sau_data <= req_data slice g and rsp_idx <= g;
    - latches lat <= max(cfg_latency,1) and sets rr_ptr <= (g+1) mod NUM_REQS;
    - moves to ISSUE.
  - With no valid request, the block stays in IDLE and rr_ptr is unchanged.
- ISSUE:
  - sau_start=1 for exactly this one cycle.
  - counter <= lat.
  - Next state is COMPUTE.
- COMPUTE:
  - counter decrements each cycle.
  - In the cycle where counter==1, rsp_data <= sau_result and the next state is RESP.
  - The SAU result is therefore sampled lat cycles after the sau_start cycle.
- RESP:
  - rsp_valid=1. rsp_data and rsp_idx are held stable while rsp_ready=0 (unbounded backpressure).
  - On rsp_valid && rsp_ready the next state is IDLE and rsp_valid drops the following cycle.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Timing for an accept in cycle A:
  - sau_start is high in A+1.
  - The result is sampled at the end of A+1+lat.
  - rsp_valid is first high in A+2+lat.
  - Minimum occupancy is lat+3 cycles per operation when rsp_ready is held at 1.
- Handshake and data rules:
  - Requesters may drop req_valid before it is granted, with no side effects.
  - cfg_latency changes after accept do not affect the operation in flight.
  - Payload is not modified; widths are passed through exactly.
  - counter is LATW bits wide and never wraps, because lat is at least 1.
- Fairness: a continuously valid requester is granted within NUM_REQS operations.

Test Plan:
- Single request, NUM_REQS=4, cfg_latency=3:
  - Stimulus: req_valid=0001 in cycle 0; SAU model returns 0xDEAD in cycle 4.
  - Required: req_ready[0]=1 in cycle 0; sau_start=1 in cycle 1 only; sau_data=req_data[0]; rsp_valid=1 from cycle 5 with rsp_idx=0, rsp_data=0xDEAD; busy=0 after the handshake.
- Round-robin:
  - Stimulus: req_valid=1111 held, rsp_ready=1.
  - Required: grant order 0,1,2,3,0; each grant 6 cycles apart (lat=3).
  - Stimulus: then only requesters 1 and 3 valid.
  - Required: grants alternate 1,3,1.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles in RESP.
  - Required: rsp_valid, rsp_data and rsp_idx stable throughout; req_ready=0000 despite pending requests; on rsp_ready=1, IDLE the next cycle.
- Latency edge cases:
  - Stimulus: cfg_latency=0.
  - Required: behaves as lat=1, with the result sampled in the cycle after sau_start.
  - Stimulus: cfg_latency=15.
  - Required: rsp_valid at A+17.
  - Stimulus: cfg_latency changed mid-COMPUTE.
  - Required: no effect on the operation in flight.
- Reset mid-operation:
  - Stimulus: reset_n asserted asynchronously during COMPUTE.
  - Required: outputs go to reset values immediately without a clock edge; no rsp_valid afterwards; rr_ptr=0, so the next grant with req_valid=1111 is requester 0.
- Withdrawn request:
  - Stimulus: requester 2 raises req_valid while busy, then drops it before IDLE.
  - Required: no grant to requester 2; rr_ptr advances only on actual grants.
